// File: rtl/periph_bus_fabric_if.sv
// -----------------------------------------------------------------------------
// periph_bus_fabric_if
// CPU data-port handshake bundle for the peripheral bus fabric.
//   master modport : the CPU side. Drives the request, receives the response.
//   slave  modport : the fabric side. Receives the request, drives the response.
// Signals:
//   m_addr / m_wdata / m_be   request address, write data, byte enables
//   m_wr_en / m_rd_en         request lines, held by the master until m_ready
//   m_rdata                   read response data, held until the next response
//   m_ready                   one-cycle transaction-done pulse
//   m_err                     error qualifier, meaningful only with m_ready
// -----------------------------------------------------------------------------
interface periph_bus_fabric_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic [DATA_WIDTH/8-1:0] m_be;
    logic                    m_wr_en;
    logic                    m_rd_en;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic                    m_ready;
    logic                    m_err;

    modport master (
        output m_addr, m_wdata, m_be, m_wr_en, m_rd_en,
        input  m_rdata, m_ready, m_err
    );

    modport slave (
        input  m_addr, m_wdata, m_be, m_wr_en, m_rd_en,
        output m_rdata, m_ready, m_err
    );
endinterface

// File: rtl/periph_bus_fabric.sv
// -----------------------------------------------------------------------------
// periph_bus_fabric
// Registered request/response interconnect between the CPU data port and
// NUM_SLAVES memory-mapped slaves. Each slave owns an address window
// (base/mask). A request is latched in IDLE, the matching slave is strobed in
// WAIT until it answers (or the timeout expires), and the result is returned
// as a one-cycle m_ready pulse in RESP. Unmapped or stalled accesses answer
// with m_err and are recorded in a sticky error flag plus error address.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cpu             CPU-side handshake (periph_bus_fabric_if, slave modport)
//   s_sel           one-hot slave select
//   s_addr/s_wdata/s_be  latched request, shared by all slaves
//   s_we / s_re     write / read strobe, qualified by s_sel
//   s_rdata         packed slave read data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_valid         per-slave response valid
//   err_clear       clears err_flag
//   err_flag        sticky bus-error flag
//   err_addr        address of the most recent errored access
// -----------------------------------------------------------------------------
module periph_bus_fabric #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0200_4000, 32'h0200_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFF8_0000, 32'hFFF0_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    periph_bus_fabric_if.slave               cpu,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    output logic                             s_we,
    output logic                             s_re,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_valid,
    input  logic                             err_clear,
    output logic                             err_flag,
    output logic [ADDR_WIDTH-1:0]            err_addr
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q,    state_d;
    logic [IDX_WIDTH-1:0]    idx_q,      idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [BE_WIDTH-1:0]     be_q,       be_d;
    logic [NUM_SLAVES-1:0]   sel_q,      sel_d;
    logic                    we_q,       we_d;
    logic                    re_q,       re_d;
    logic [CNT_WIDTH-1:0]    cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q,    rdata_d;
    logic                    merr_q,     merr_d;
    logic                    err_flag_q, err_flag_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

    logic                    hit;
    logic [IDX_WIDTH-1:0]    hit_idx;
    logic                    req;
    logic                    slave_valid;
    logic [DATA_WIDTH-1:0]   slave_rdata;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic                    timeout_hit;

    // Address decode on the live request. Scanning high-to-low makes the
    // lowest matching slot the last writer, so it wins on overlapping windows.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((cpu.m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
        end
    end

    assign req         = cpu.m_wr_en | cpu.m_rd_en;
    // Only the selected slave's response is observed; others are ignored.
    assign slave_valid = s_valid[idx_q];
    assign slave_rdata = s_rdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        sel_d      = sel_q;
        we_d       = we_q;
        re_d       = re_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        merr_d     = merr_q;
        // A new error in the same cycle overrides the clear below.
        err_flag_d = err_flag_q & ~err_clear;
        err_addr_d = err_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = cpu.m_addr;
                    wdata_d = cpu.m_wdata;
                    be_d    = cpu.m_be;
                    if (hit) begin
                        state_d = ST_WAIT;
                        idx_d   = hit_idx;
                        sel_d   = NUM_SLAVES'(1) << hit_idx;
                        we_d    = cpu.m_wr_en;
                        re_d    = ~cpu.m_wr_en;   // write wins when both are set
                        cnt_d   = '0;
                    end else begin
                        state_d    = ST_RESP;
                        merr_d     = 1'b1;
                        rdata_d    = '0;
                        err_flag_d = 1'b1;
                        err_addr_d = cpu.m_addr;
                    end
                end
            end

            ST_WAIT: begin
                if (slave_valid) begin
                    state_d = ST_RESP;
                    merr_d  = 1'b0;
                    rdata_d = re_q ? slave_rdata : '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d    = ST_RESP;
                        merr_d     = 1'b1;
                        rdata_d    = '0;
                        sel_d      = '0;
                        we_d       = 1'b0;
                        re_d       = 1'b0;
                        err_flag_d = 1'b1;
                        err_addr_d = addr_q;
                    end
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            merr_q     <= 1'b0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            re_q       <= re_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            merr_q     <= merr_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign cpu.m_ready = (state_q == ST_RESP);
    assign cpu.m_rdata = rdata_q;
    assign cpu.m_err   = merr_q;
    assign s_sel       = sel_q;
    assign s_addr      = addr_q;
    assign s_wdata     = wdata_q;
    assign s_be        = be_q;
    assign s_we        = we_q;
    assign s_re        = re_q;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;

endmodule
